reservation_station_param: RTL and testbench

//  Parametrised reservation station for the Tomasulo core: DEPTH entries, NUM_CDB result buses snooped in parallel.

---
 rtl/tomasulo_pkg.sv | 34 +++
 rtl/rs_age_matrix.sv | 40 ++++
 rtl/reservation_station_param.sv | 195 +++++++++++++++++++
 tb/tb_reservation_station_param.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core: default field widths, opcode values,
// CDB channel numbering and helpers for building and splitting station tags.
package tomasulo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_OP_W   = 4;
  localparam int DEF_REG_W  = 4;
  localparam int DEF_TAG_W  = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_LD  = 4'd8;
  localparam logic [3:0] OP_ST  = 4'd9;

  localparam int CDB_ALU = 0;
  localparam int CDB_MEM = 1;

  // Bit offset of channel ch inside a flat per-channel bus of field width w.
  function automatic int cdb_lsb(input int ch, input int w);
    return ch * w;
  endfunction

  // Tag = {station_id, idx}; callers size-cast the result to their TAG_W.
  function automatic logic [31:0] tag_build(input int station_id, input int idx, input int idx_w);
    return 32'((station_id << idx_w) | idx);
  endfunction

  function automatic int tag_index(input logic [31:0] tag, input int idx_w);
    return int'(tag & ((32'd1 << idx_w) - 32'd1));
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Relative-age tracker for the reservation station: older[i][j]=1 means entry j
// was allocated before entry i. Selects the oldest entry among a ready vector.
module rs_age_matrix
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] busy,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] oldest
);

  logic [DEPTH-1:0] older [DEPTH];

  // An entry leaving at this edge must not be recorded as older than the newcomer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc[i]) older[i] <= busy & ~free;
        else          older[i] <= older[i] & ~free;
      end
    end
  end

  always_comb begin
    oldest = '0;
    for (int i = 0; i < DEPTH; i++)
      oldest[i] = ready[i] & ~|(older[i] & ready);
  end

endmodule

// File: rtl/reservation_station_param.sv
// Parametrised reservation station: DEPTH entries, NUM_CDB snooped result buses,
// oldest-ready dispatch into a registered valid/ready functional-unit port.
module reservation_station_param
  import tomasulo_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 16,
  parameter int OP_W       = 4,
  parameter int REG_W      = 4,
  parameter int TAG_W      = 4,
  parameter int STATION_ID = 0,
  parameter int NUM_CDB    = 2,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [OP_W-1:0]           issue_op,
  input  logic [REG_W-1:0]          issue_dest,
  input  logic [DATA_W-1:0]         issue_vj,
  input  logic [DATA_W-1:0]         issue_vk,
  input  logic [TAG_W-1:0]          issue_qj,
  input  logic [TAG_W-1:0]          issue_qk,
  input  logic                      issue_pj,
  input  logic                      issue_pk,
  output logic [TAG_W-1:0]          issue_tag,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic                      disp_valid,
  input  logic                      disp_ready,
  output logic [OP_W-1:0]           disp_op,
  output logic [REG_W-1:0]          disp_dest,
  output logic [TAG_W-1:0]          disp_tag,
  output logic [DATA_W-1:0]         disp_vj,
  output logic [DATA_W-1:0]         disp_vk,
  output logic [IDX_W:0]            count
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  pj;
  logic [DEPTH-1:0]  pk;
  logic [OP_W-1:0]   e_op   [DEPTH];
  logic [REG_W-1:0]  e_dest [DEPTH];
  logic [DATA_W-1:0] e_vj   [DEPTH];
  logic [DATA_W-1:0] e_vk   [DEPTH];
  logic [TAG_W-1:0]  e_qj   [DEPTH];
  logic [TAG_W-1:0]  e_qk   [DEPTH];
  logic [DATA_W:0]   wake_j [DEPTH];
  logic [DATA_W:0]   wake_k [DEPTH];

  logic [DEPTH-1:0]  alloc_vec;
  logic [DEPTH-1:0]  free_vec;
  logic [DEPTH-1:0]  ready_vec;
  logic [DEPTH-1:0]  oldest;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W:0]    busy_cnt;
  logic              issue_fire;
  logic              load;
  logic [DATA_W:0]   byp_j;
  logic [DATA_W:0]   byp_k;

  logic [0:0]        state_p1;
  logic [OP_W-1:0]   op_p1;
  logic [REG_W-1:0]  dest_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic [DATA_W-1:0] vj_p1;
  logic [DATA_W-1:0] vk_p1;

  // Returns {hit, data}; scanning downward lets the lowest matching channel win.
  function automatic logic [DATA_W:0] snoop(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        v,
    input logic [NUM_CDB*TAG_W-1:0]  t,
    input logic [NUM_CDB*DATA_W-1:0] d
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--)
      if (v[c] && t[cdb_lsb(c, TAG_W) +: TAG_W] == tag)
        r = {1'b1, d[cdb_lsb(c, DATA_W) +: DATA_W]};
    return r;
  endfunction

  always_comb begin
    busy_cnt = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) busy_cnt = busy_cnt + (IDX_W+1)'(busy[i]);
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i]) free_idx = IDX_W'(i);
  end

  assign count       = busy_cnt;
  assign issue_ready = (busy_cnt < (IDX_W+1)'(DEPTH)) & ~flush;
  assign issue_fire  = issue_valid & issue_ready;
  assign issue_tag   = TAG_W'(tag_build(STATION_ID, int'(free_idx), IDX_W));
  assign alloc_vec   = issue_fire ? (DEPTH'(1) << free_idx) : '0;
  assign ready_vec   = busy & ~pj & ~pk;
  assign load        = (|ready_vec) & ((state_p1 == ST_EMPTY) | disp_ready) & ~flush;
  assign free_vec    = load ? oldest : '0;

  always_comb begin
    byp_j = snoop(issue_qj, cdb_valid, cdb_tag, cdb_data);
    byp_k = snoop(issue_qk, cdb_valid, cdb_tag, cdb_data);
    for (int i = 0; i < DEPTH; i++) begin
      wake_j[i] = snoop(e_qj[i], cdb_valid, cdb_tag, cdb_data);
      wake_k[i] = snoop(e_qk[i], cdb_valid, cdb_tag, cdb_data);
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (oldest[i]) sel_idx = IDX_W'(i);
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .alloc   (alloc_vec),
    .free    (free_vec),
    .busy    (busy),
    .ready   (ready_vec),
    .oldest  (oldest)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   busy <= '0;
    else if (flush) busy <= '0;
    else            busy <= (busy & ~free_vec) | alloc_vec;
  end

  // Entry payload and pend flags are only meaningful while busy, so they carry no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_vec[i]) begin
        e_op[i]   <= issue_op;
        e_dest[i] <= issue_dest;
        e_qj[i]   <= issue_qj;
        e_qk[i]   <= issue_qk;
        e_vj[i]   <= (issue_pj && byp_j[DATA_W]) ? byp_j[DATA_W-1:0] : issue_vj;
        e_vk[i]   <= (issue_pk && byp_k[DATA_W]) ? byp_k[DATA_W-1:0] : issue_vk;
        pj[i]     <= issue_pj & ~byp_j[DATA_W];
        pk[i]     <= issue_pk & ~byp_k[DATA_W];
      end else if (busy[i] && !flush) begin
        if (pj[i] && wake_j[i][DATA_W]) begin
          e_vj[i] <= wake_j[i][DATA_W-1:0];
          pj[i]   <= 1'b0;
        end
        if (pk[i] && wake_k[i][DATA_W]) begin
          e_vk[i] <= wake_k[i][DATA_W-1:0];
          pk[i]   <= 1'b0;
        end
      end
    end
  end

  // ---- stage p1: dispatch register (EMPTY/FULL) ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_p1 <= ST_EMPTY;
      op_p1    <= '0;
      dest_p1  <= '0;
      tag_p1   <= '0;
      vj_p1    <= '0;
      vk_p1    <= '0;
    end else if (flush) begin
      state_p1 <= ST_EMPTY;
    end else if (load) begin
      state_p1 <= ST_FULL;
      op_p1    <= e_op[sel_idx];
      dest_p1  <= e_dest[sel_idx];
      tag_p1   <= TAG_W'(tag_build(STATION_ID, int'(sel_idx), IDX_W));
      vj_p1    <= e_vj[sel_idx];
      vk_p1    <= e_vk[sel_idx];
    end else if (state_p1 == ST_FULL && disp_ready) begin
      state_p1 <= ST_EMPTY;
    end
  end

  assign disp_valid = (state_p1 == ST_FULL);
  assign disp_op    = op_p1;
  assign disp_dest  = dest_p1;
  assign disp_tag   = tag_p1;
  assign disp_vj    = vj_p1;
  assign disp_vk    = vk_p1;

endmodule

// File: tb/tb_reservation_station_param.sv
// Self-checking bench for reservation_station_param: directed scenarios followed by
// random traffic, both compared against an issue-ordered queue model of the station.
module tb_reservation_station_param;

  localparam int DEPTH      = 4;
  localparam int DATA_W     = 16;
  localparam int OP_W       = 4;
  localparam int REG_W      = 4;
  localparam int TAG_W      = 4;
  localparam int STATION_ID = 0;
  localparam int NUM_CDB    = 2;
  localparam int IDX_W      = 2;

  logic                      clock = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      flush = 1'b0;
  logic                      issue_valid = 1'b0;
  logic                      issue_ready;
  logic [OP_W-1:0]           issue_op = '0;
  logic [REG_W-1:0]          issue_dest = '0;
  logic [DATA_W-1:0]         issue_vj = '0;
  logic [DATA_W-1:0]         issue_vk = '0;
  logic [TAG_W-1:0]          issue_qj = '0;
  logic [TAG_W-1:0]          issue_qk = '0;
  logic                      issue_pj = 1'b0;
  logic                      issue_pk = 1'b0;
  logic [TAG_W-1:0]          issue_tag;
  logic [NUM_CDB-1:0]        cdb_valid = '0;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag = '0;
  logic [NUM_CDB*DATA_W-1:0] cdb_data = '0;
  logic                      disp_valid;
  logic                      disp_ready = 1'b1;
  logic [OP_W-1:0]           disp_op;
  logic [REG_W-1:0]          disp_dest;
  logic [TAG_W-1:0]          disp_tag;
  logic [DATA_W-1:0]         disp_vj;
  logic [DATA_W-1:0]         disp_vk;
  logic [IDX_W:0]            count;

  always #5 clock = ~clock;

  reservation_station_param #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W), .REG_W(REG_W),
    .TAG_W(TAG_W), .STATION_ID(STATION_ID), .NUM_CDB(NUM_CDB)
  ) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_dest(issue_dest),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_pj(issue_pj), .issue_pk(issue_pk), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_dest(disp_dest), .disp_tag(disp_tag),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .count(count)
  );

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic              pj;
    logic              pk;
    int                idx;
  } ent_t;

  ent_t q[$];     // resident ops, oldest first
  ent_t m_d;      // op held in the dispatch register
  bit   m_dv = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First valid channel (ascending) carrying tag t supplies the data.
  function automatic bit snoop_m(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
    d = '0;
    for (int c = 0; c < NUM_CDB; c++)
      if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) begin
        d = cdb_data[c*DATA_W +: DATA_W];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic int low_free();
    for (int k = 0; k < DEPTH; k++) begin
      bit used = 1'b0;
      foreach (q[n]) if (q[n].idx == k) used = 1'b1;
      if (!used) return k;
    end
    return -1;
  endfunction

  task automatic model_step(input int fi);
    bit do_issue;
    int pos;
    ent_t e;
    logic [DATA_W-1:0] d;
    if (flush) begin
      q.delete();
      m_dv = 1'b0;
      return;
    end
    do_issue = issue_valid && (q.size() < DEPTH);
    if (!m_dv || disp_ready) begin
      pos = -1;
      for (int k = 0; k < q.size(); k++)
        if (!q[k].pj && !q[k].pk) begin pos = k; break; end
      if (pos >= 0) begin
        m_d = q[pos];
        q.delete(pos);
        m_dv = 1'b1;
      end else begin
        m_dv = 1'b0;
      end
    end
    for (int k = 0; k < q.size(); k++) begin
      e = q[k];
      if (e.pj && snoop_m(e.qj, d)) begin e.vj = d; e.pj = 1'b0; end
      if (e.pk && snoop_m(e.qk, d)) begin e.vk = d; e.pk = 1'b0; end
      q[k] = e;
    end
    if (do_issue) begin
      e.op = issue_op; e.dest = issue_dest;
      e.vj = issue_vj; e.vk = issue_vk;
      e.qj = issue_qj; e.qk = issue_qk;
      e.pj = issue_pj; e.pk = issue_pk;
      e.idx = fi;
      if (e.pj && snoop_m(e.qj, d)) begin e.vj = d; e.pj = 1'b0; end
      if (e.pk && snoop_m(e.qk, d)) begin e.vk = d; e.pk = 1'b0; end
      q.push_back(e);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; this checks, steps the model and crosses one edge.
  task automatic cycle();
    int fi;
    bit er;
    #3;
    er = (q.size() < DEPTH) && !flush;
    chk("issue_ready", 32'(issue_ready), 32'(er));
    fi = low_free();
    if (er) chk("issue_tag", 32'(issue_tag), 32'(STATION_ID * DEPTH + fi));
    model_step(fi);
    @(posedge clock);
    #1;
    chk("disp_valid", 32'(disp_valid), 32'(m_dv));
    if (m_dv) begin
      chk("disp_op",   32'(disp_op),   32'(m_d.op));
      chk("disp_dest", 32'(disp_dest), 32'(m_d.dest));
      chk("disp_tag",  32'(disp_tag),  32'(STATION_ID * DEPTH + m_d.idx));
      chk("disp_vj",   32'(disp_vj),   32'(m_d.vj));
      chk("disp_vk",   32'(disp_vk),   32'(m_d.vk));
    end
    chk("count", 32'(count), 32'(q.size()));
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    cdb_valid   = '0;
    flush       = 1'b0;
  endtask

  task automatic iss(input int op, input int dest, input int vj, input int vk,
                     input bit pj, input int qj, input bit pk, input int qk);
    issue_valid = 1'b1;
    issue_op    = OP_W'(op);
    issue_dest  = REG_W'(dest);
    issue_vj    = DATA_W'(vj);
    issue_vk    = DATA_W'(vk);
    issue_pj    = pj;
    issue_qj    = TAG_W'(qj);
    issue_pk    = pk;
    issue_qk    = TAG_W'(qk);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_disp_vj", 32'(disp_vj), 32'd0);
    chk("rst_disp_tag", 32'(disp_tag), 32'd0);
    reset_n = 1'b1;

    // ready issue goes straight through
    disp_ready = 1'b1;
    iss(3, 5, 10, 20, 0, 0, 0, 0);
    cycle();
    idle();
    cycle();
    chk("t2_valid", 32'(disp_valid), 32'd1);
    chk("t2_op", 32'(disp_op), 32'd3);
    chk("t2_dest", 32'(disp_dest), 32'd5);
    chk("t2_vj", 32'(disp_vj), 32'd10);
    chk("t2_vk", 32'(disp_vk), 32'd20);
    chk("t2_tag", 32'(disp_tag), 32'd0);
    cycle();

    // wake-up from the memory channel
    iss(1, 2, 0, 5, 1, 7, 0, 0);
    cycle();
    idle();
    cycle();
    cdb_valid = 2'b10;
    cdb_tag   = {4'd7, 4'd0};
    cdb_data  = {16'h1234, 16'h0000};
    cycle();
    chk("t3_not_yet", 32'(disp_valid), 32'd0);
    idle();
    cycle();
    chk("t3_valid", 32'(disp_valid), 32'd1);
    chk("t3_vj", 32'(disp_vj), 32'h1234);
    cycle();

    // issue bypass with both channels carrying the same tag
    iss(2, 6, 77, 0, 0, 0, 1, 9);
    cdb_valid = 2'b11;
    cdb_tag   = {4'd9, 4'd9};
    cdb_data  = {16'hBBBB, 16'hAAAA};
    cycle();
    idle();
    cycle();
    chk("t4_vk", 32'(disp_vk), 32'hAAAA);
    cycle();

    // fill the station behind a stalled functional unit, then drain in order
    disp_ready = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      iss(n, n, 100 + n, n, 0, 0, 0, 0);
      cycle();
    end
    chk("t5_count", 32'(count), 32'd4);
    iss(6, 6, 200, 0, 0, 0, 0, 0);
    cycle();
    chk("t5_blocked", 32'(count), 32'd4);
    idle();
    chk("t5_ready_low", 32'(issue_ready), 32'd0);
    chk("t5_head", 32'(disp_vj), 32'd101);
    disp_ready = 1'b1;
    for (int n = 2; n <= 5; n++) begin
      cycle();
      chk("t5_order", 32'(disp_vj), 32'(100 + n));
    end
    cycle();
    chk("t5_drained", 32'(disp_valid), 32'd0);

    // flush wins over a concurrent issue
    disp_ready = 1'b0;
    iss(4, 1, 1, 1, 0, 0, 0, 0);
    cycle();
    iss(5, 2, 0, 0, 1, 12, 0, 0);
    cycle();
    iss(6, 3, 0, 0, 0, 0, 1, 13);
    cycle();
    iss(7, 4, 0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    cycle();
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_valid", 32'(disp_valid), 32'd0);
    idle();
    cycle();
    chk("t6_not_taken", 32'(count), 32'd0);

    // asynchronous reset in the middle of traffic
    for (int n = 0; n < 4; n++) begin
      iss(n, n, 50 + n, 0, 0, 0, 0, 0);
      cycle();
    end
    idle();
    chk("t1_pre_count", 32'(count), 32'd3);
    chk("t1_pre_valid", 32'(disp_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_valid", 32'(disp_valid), 32'd0);
    q.delete();
    m_dv = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    disp_ready = 1'b1;

    // random traffic
    for (int it = 0; it < 800; it++) begin
      issue_valid = ($urandom_range(9, 0) < 6);
      issue_op    = OP_W'($urandom);
      issue_dest  = REG_W'($urandom);
      issue_vj    = DATA_W'($urandom);
      issue_vk    = DATA_W'($urandom);
      issue_pj    = ($urandom_range(9, 0) < 4);
      issue_pk    = ($urandom_range(9, 0) < 3);
      issue_qj    = TAG_W'($urandom_range(11, 8));
      issue_qk    = TAG_W'($urandom_range(11, 8));
      cdb_valid   = NUM_CDB'($urandom);
      cdb_tag     = {TAG_W'($urandom_range(11, 8)), TAG_W'($urandom_range(11, 8))};
      cdb_data    = {DATA_W'($urandom), DATA_W'($urandom)};
      disp_ready  = ($urandom_range(9, 0) < 7);
      flush       = ($urandom_range(99, 0) < 2);
      cycle();
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
